// File: rtl/mipsmulti.sv
// Multicycle 32-bit MIPS core: shared ALU, single memory port, FSM controller.
// Executes lw, sw, add, sub, and, or, slt, beq, addi and j. Every other opcode
// is treated as a nop that costs a fetch and a decode cycle.
module mipsmulti (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] adr,
    output logic [31:0] writedata,
    output logic        memwrite,
    input  logic [31:0] readdata
);

    // Controller states; encodings 12..15 are unreachable.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Architectural state
    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] data_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] aluout_r;
    logic [31:0] rf_r [0:31];

    // Control signals
    logic        iord_s;
    logic        irwrite_s;
    logic        alusrca_s;
    logic [1:0]  alusrcb_s;
    logic [1:0]  pcsrc_s;
    logic [1:0]  aluop_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic        regwrite_s;
    logic        regdst_s;
    logic        memtoreg_s;
    logic        memwrite_s;

    // Datapath nets
    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] signimm_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;
    logic [4:0]  wa_s;
    logic [31:0] wd_s;
    logic [31:0] srca_s;
    logic [31:0] srcb_s;
    logic [31:0] diff_s;
    logic [31:0] aluresult_s;
    logic        zero_s;
    alu_t        alucontrol_s;
    logic [31:0] pcnext_s;
    logic        pcen_s;

    assign op_s      = instr_r[31:26];
    assign rs_s      = instr_r[25:21];
    assign rt_s      = instr_r[20:16];
    assign rd_s      = instr_r[15:11];
    assign funct_s   = instr_r[5:0];
    assign signimm_s = {{16{instr_r[15]}}, instr_r[15:0]};

    // Controller state register; reset always lands in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Controller next-state and per-state control decode
    always_comb begin
        state_next_s = S_FETCH;
        iord_s       = 1'b0;
        irwrite_s    = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        aluop_s      = 2'b00;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        regwrite_s   = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        memwrite_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                irwrite_s    = 1'b1;
                alusrcb_s    = 2'b01;
                pcwrite_s    = 1'b1;
                state_next_s = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut
                alusrcb_s = 2'b11;
                case (op_s)
                    OP_LW:    state_next_s = S_MEMADR;
                    OP_SW:    state_next_s = S_MEMADR;
                    OP_RTYPE: state_next_s = S_RTYPEEX;
                    OP_BEQ:   state_next_s = S_BEQEX;
                    OP_ADDI:  state_next_s = S_ADDIEX;
                    OP_J:     state_next_s = S_JEX;
                    default:  state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op_s == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord_s       = 1'b1;
                state_next_s = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_s   = 1'b1;
                memtoreg_s   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                iord_s       = 1'b1;
                memwrite_s   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca_s    = 1'b1;
                aluop_s      = 2'b10;
                state_next_s = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite_s   = 1'b1;
                regdst_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BEQEX: begin
                alusrca_s    = 1'b1;
                pcsrc_s      = 2'b01;
                aluop_s      = 2'b01;
                branch_s     = 1'b1;
                state_next_s = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
                state_next_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JEX: begin
                pcsrc_s      = 2'b10;
                pcwrite_s    = 1'b1;
                state_next_s = S_FETCH;
            end
            default: begin
                state_next_s = S_FETCH;
            end
        endcase
    end

    // ALU operation select from aluop and the R-type funct field
    always_comb begin
        alucontrol_s = ALU_ADD;
        case (aluop_s)
            2'b00: alucontrol_s = ALU_ADD;
            2'b01: alucontrol_s = ALU_SUB;
            2'b10: begin
                case (funct_s)
                    FN_ADD:  alucontrol_s = ALU_ADD;
                    FN_SUB:  alucontrol_s = ALU_SUB;
                    FN_AND:  alucontrol_s = ALU_AND;
                    FN_OR:   alucontrol_s = ALU_OR;
                    FN_SLT:  alucontrol_s = ALU_SLT;
                    default: alucontrol_s = ALU_ADD;
                endcase
            end
            default: alucontrol_s = ALU_ADD;
        endcase
    end

    // Register file read ports; r0 always reads as zero
    always_comb begin
        if (rs_s == 5'd0) begin
            rd1_s = 32'd0;
        end else begin
            rd1_s = rf_r[rs_s];
        end
        if (rt_s == 5'd0) begin
            rd2_s = 32'd0;
        end else begin
            rd2_s = rf_r[rt_s];
        end
    end

    assign wa_s = regdst_s   ? rd_s   : rt_s;
    assign wd_s = memtoreg_s ? data_r : aluout_r;

    // ALU operand muxes
    always_comb begin
        srca_s = alusrca_s ? a_r : pc_r;
        srcb_s = b_r;
        case (alusrcb_s)
            2'b00:   srcb_s = b_r;
            2'b01:   srcb_s = 32'd4;
            2'b10:   srcb_s = signimm_s;
            2'b11:   srcb_s = {signimm_s[29:0], 2'b00};
            default: srcb_s = b_r;
        endcase
    end

    // slt uses only the sign of the difference, so it is not overflow-corrected
    assign diff_s = srca_s + ~srcb_s + 32'd1;

    // Shared ALU
    always_comb begin
        aluresult_s = srca_s + srcb_s;
        case (alucontrol_s)
            ALU_ADD: aluresult_s = srca_s + srcb_s;
            ALU_SUB: aluresult_s = diff_s;
            ALU_AND: aluresult_s = srca_s & srcb_s;
            ALU_OR:  aluresult_s = srca_s | srcb_s;
            ALU_SLT: aluresult_s = {31'd0, diff_s[31]};
            default: aluresult_s = srca_s + srcb_s;
        endcase
    end

    assign zero_s = (aluresult_s == 32'd0);

    // Next-PC select: PC+4 / branch target in ALUOut / jump target
    always_comb begin
        pcnext_s = aluresult_s;
        case (pcsrc_s)
            2'b00:   pcnext_s = aluresult_s;
            2'b01:   pcnext_s = aluout_r;
            2'b10:   pcnext_s = {pc_r[31:28], instr_r[25:0], 2'b00};
            default: pcnext_s = aluresult_s;
        endcase
    end

    assign pcen_s = pcwrite_s | (branch_s & zero_s);

    // Program counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= 32'd0;
        end else if (pcen_s) begin
            pc_r <= pcnext_s;
        end
    end

    // Instruction register, loaded only in FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_r <= 32'd0;
        end else if (irwrite_s) begin
            instr_r <= readdata;
        end
    end

    // Non-architectural pipeline latches between cycles, loaded every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r   <= 32'd0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            aluout_r <= 32'd0;
        end else begin
            data_r   <= readdata;
            a_r      <= rd1_s;
            b_r      <= rd2_s;
            aluout_r <= aluresult_s;
        end
    end

    // Register file write port; contents survive reset
    always_ff @(posedge clk) begin
        if (regwrite_s && (wa_s != 5'd0)) begin
            rf_r[wa_s] <= wd_s;
        end
    end

    assign adr       = iord_s ? aluout_r : pc_r;
    assign writedata = b_r;
    assign memwrite  = memwrite_s;

endmodule

// File: tb/tb_mipsmulti.sv
// Self-checking bench for mipsmulti: small programs run from a bench-owned
// memory; every expected store (address, data, cycle) is queued up front and
// a negedge monitor pops and compares each store the core makes.
module tb_mipsmulti;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        memwrite;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [31:0] mem [0:63];
    logic        ld_en = 1'b0;
    logic        ld_clr = 1'b0;
    logic [5:0]  ld_idx = 6'd0;
    logic [31:0] ld_data = 32'd0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } store_t;
    store_t exp_q[$];
    store_t mon_e;

    mipsmulti dut (
        .clk(clk),
        .reset(reset),
        .adr(adr),
        .writedata(writedata),
        .memwrite(memwrite),
        .readdata(readdata)
    );

    always #5 clk = ~clk;

    assign readdata = mem[adr[7:2]];

    // Memory: bench loading has priority, otherwise the core's stores
    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end else if (memwrite) begin
            mem[adr[7:2]] <= writedata;
        end
    end

    // Cycle index since reset release (cycle 0 is the first fetch)
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Store scoreboard
    always @(negedge clk) begin
        if (!reset && memwrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: adr=%h data=%h cyc=%0d, required no store", adr, writedata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (adr !== mon_e.a || writedata !== mon_e.d || cyc !== mon_e.c) begin
                    errors++;
                    $display("FAIL store: adr=%h data=%h cyc=%0d, required adr=%h data=%h cyc=%0d",
                             adr, writedata, cyc, mon_e.a, mon_e.d, mon_e.c);
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [31:0] v;
        v = {op, rs[4:0], rt[4:0], imm[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
        logic [31:0] v;
        v = {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b00000, fn};
        return v;
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        logic [31:0] v;
        v = {6'b000010, target[25:0]};
        return v;
    endfunction

    task automatic start_prog();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
    endtask

    task automatic put_word(input int idx, input logic [31:0] w);
        ld_idx  = idx[5:0];
        ld_data = w;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        start_prog();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (adr !== 32'd0 || memwrite !== 1'b0 || writedata !== 32'd0) begin
                errors++;
                $display("FAIL reset_hold: adr=%h mw=%b wd=%h, required 0/0/0", adr, memwrite, writedata);
            end
        end
        reset = 1'b0;
        checks++;
        if (adr !== 32'd0 || memwrite !== 1'b0 || writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_release: adr=%h mw=%b wd=%h, required 0/0/0", adr, memwrite, writedata);
        end
        @(negedge clk);
        checks++;
        if (adr !== 32'd4) begin
            errors++;
            $display("FAIL first_fetch: adr=%h, required 00000004", adr);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_sw_timing();
        logic exp_mw;
        start_prog();
        put_word(0, enc_i(6'b001000, 0, 2, 5));
        put_word(1, enc_i(6'b101011, 0, 2, 84));
        put_word(2, enc_j(2));
        exp_q.push_back('{32'd84, 32'd5, 7});
        release_reset();
        for (int k = 0; k < 14; k++) begin
            exp_mw = (cyc == 7) ? 1'b1 : 1'b0;
            checks++;
            if (memwrite !== exp_mw) begin
                errors++;
                $display("FAIL sw_memwrite cyc=%0d: mw=%b, required %b", cyc, memwrite, exp_mw);
            end
            if (cyc == 7) begin
                checks++;
                if (adr !== 32'd84 || writedata !== 32'd5) begin
                    errors++;
                    $display("FAIL sw_cycle7: adr=%h wd=%h, required 00000054/00000005", adr, writedata);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sw_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_rtype_chain();
        start_prog();
        put_word(0,  enc_i(6'b001000, 0, 3, 12));
        put_word(1,  enc_i(6'b001000, 0, 7, 3));
        put_word(2,  enc_r(4, 3, 7, 6'b100010));
        put_word(3,  enc_r(5, 3, 7, 6'b100101));
        put_word(4,  enc_r(6, 3, 7, 6'b100100));
        put_word(5,  enc_r(8, 7, 3, 6'b101010));
        put_word(6,  enc_r(10, 3, 7, 6'b100111));
        put_word(7,  enc_i(6'b101011, 0, 4, 200));
        put_word(8,  enc_i(6'b101011, 0, 5, 204));
        put_word(9,  enc_i(6'b101011, 0, 6, 208));
        put_word(10, enc_i(6'b101011, 0, 8, 212));
        put_word(11, enc_i(6'b101011, 0, 10, 216));
        put_word(12, enc_j(12));
        exp_q.push_back('{32'd200, 32'd9,  31});
        exp_q.push_back('{32'd204, 32'd15, 35});
        exp_q.push_back('{32'd208, 32'd0,  39});
        exp_q.push_back('{32'd212, 32'd1,  43});
        exp_q.push_back('{32'd216, 32'd15, 47});
        release_reset();
        repeat (60) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rtype_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_lw_sw();
        start_prog();
        put_word(0, enc_i(6'b001000, 0, 2, -7));
        put_word(1, enc_i(6'b101011, 0, 2, 80));
        put_word(2, enc_i(6'b100011, 0, 9, 80));
        put_word(3, enc_i(6'b101011, 0, 9, 84));
        put_word(4, enc_j(4));
        exp_q.push_back('{32'd80, 32'hFFFF_FFF9, 7});
        exp_q.push_back('{32'd84, 32'hFFFF_FFF9, 16});
        release_reset();
        repeat (30) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL lwsw_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_beq();
        start_prog();
        put_word(0,  enc_i(6'b001000, 0, 2, 7));
        put_word(1,  enc_i(6'b001000, 0, 3, 7));
        put_word(2,  enc_i(6'b000100, 2, 3, 1));
        put_word(3,  enc_i(6'b101011, 0, 2, 220));
        put_word(4,  enc_i(6'b000100, 2, 0, 1));
        put_word(5,  enc_i(6'b101011, 0, 3, 224));
        put_word(6,  enc_i(6'b001000, 0, 4, 3));
        put_word(7,  enc_i(6'b001000, 4, 4, -1));
        put_word(8,  enc_i(6'b101011, 0, 4, 228));
        put_word(9,  enc_i(6'b000100, 4, 0, 1));
        put_word(10, enc_i(6'b000100, 0, 0, -4));
        put_word(11, enc_i(6'b101011, 0, 4, 232));
        put_word(12, enc_j(12));
        exp_q.push_back('{32'd224, 32'd7, 17});
        exp_q.push_back('{32'd228, 32'd2, 29});
        exp_q.push_back('{32'd228, 32'd1, 43});
        exp_q.push_back('{32'd228, 32'd0, 57});
        exp_q.push_back('{32'd232, 32'd0, 64});
        release_reset();
        for (int k = 0; k < 75; k++) begin
            if (cyc == 11) begin
                checks++;
                if (adr !== 32'd16) begin
                    errors++;
                    $display("FAIL beq_taken: adr=%h, required 00000010", adr);
                end
            end
            if (cyc == 14) begin
                checks++;
                if (adr !== 32'd20) begin
                    errors++;
                    $display("FAIL beq_not_taken: adr=%h, required 00000014", adr);
                end
            end
            if (cyc == 36) begin
                checks++;
                if (adr !== 32'd28) begin
                    errors++;
                    $display("FAIL beq_backward: adr=%h, required 0000001c", adr);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL beq_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_jump_nop();
        start_prog();
        put_word(0,  enc_i(6'b001000, 0, 5, 1));
        put_word(1,  enc_j(32'h12));
        put_word(18, enc_i(6'b001001, 0, 5, 99));
        put_word(19, enc_i(6'b101011, 0, 5, 236));
        put_word(20, enc_j(20));
        exp_q.push_back('{32'd236, 32'd1, 12});
        release_reset();
        for (int k = 0; k < 25; k++) begin
            if (cyc == 7) begin
                checks++;
                if (adr !== 32'h48) begin
                    errors++;
                    $display("FAIL jump_target: adr=%h, required 00000048", adr);
                end
            end
            if (cyc == 9) begin
                checks++;
                if (adr !== 32'h4C) begin
                    errors++;
                    $display("FAIL nop_pc: adr=%h, required 0000004c", adr);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL jump_drain: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        start_prog();
        put_word(0,  enc_i(6'b001000, 0, 2, 5));
        put_word(1,  enc_i(6'b101011, 0, 2, 84));
        put_word(2,  enc_j(2));
        put_word(21, 32'hDEAD_BEEF);
        release_reset();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (memwrite !== 1'b0 || adr !== 32'd0 || writedata !== 32'd0) begin
            errors++;
            $display("FAIL abort_outputs: adr=%h mw=%b wd=%h, required 0/0/0", adr, memwrite, writedata);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mem[21] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL abort_mem: mem[84]=%h, required deadbeef", mem[21]);
        end
    endtask

    initial begin
        test_reset();
        test_sw_timing();
        test_rtype_chain();
        test_lw_sw();
        test_beq();
        test_jump_nop();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mipsmulti.md
# mipsmulti

Multicycle 32-bit MIPS processor core: one shared ALU, one unified instruction/data memory port, and a 12-state FSM controller. It sits under the system top level beside a word-addressed memory with combinational read and synchronous write. The core executes lw, sw, add, sub, and, or, slt, beq, addi and j.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high; clock clk.
- adr  out  32  memory byte address; PC when iord=0, ALUOut when iord=1.
- writedata  out  32  store data (B register).
- memwrite  out  1  memory write strobe; memory writes on the rising clk edge while high.
- readdata  in  32  memory read data, combinational from adr.

## Operation
- Architectural registers:
  - PC: enable = pcwrite | (branch & zero).
  - IR: enable = irwrite.
  - Data, A, B and ALUOut load every cycle.
  - 32x32 register file: two combinational read ports (rs=IR[25:21], rt=IR[20:16]), one synchronous write port. Reading r0 returns 0.
- Write register = rd (IR[15:11]) if regdst, else rt. Write data = Data if memtoreg, else ALUOut.
- SrcA = A if alusrca, else PC.
- SrcB by alusrcb: 00=B, 01=4, 10=signimm, 11=signimm<<2.
- Next PC by pcsrc: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}.
- ALU control by aluop:
  - 00: add.
  - 01: sub.
  - 10: decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct decodes as add.
- ALU: sub = a+~b+1. slt = sign bit of the subtraction, zero-extended. zero = (result==0).
- FSM states and asserted controls (unlisted controls are 0):
  - FETCH: iord=0, irwrite, alusrcb=01, pcsrc=00, pcwrite. Next state DECODE.
  - DECODE: alusrcb=11. Next state by opcode:
    - lw (100011) or sw (101011): MEMADR.
    - R-type (000000): RTYPEEX.
    - beq (000100): BEQEX.
    - addi (001000): ADDIEX.
    - j (000010): JEX.
    - any other opcode: FETCH (executes as a nop).
  - MEMADR: alusrca, alusrcb=10. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD: iord. Next state MEMWB.
  - MEMWB: regwrite, memtoreg, regdst=0. Next state FETCH.
  - MEMWR: iord, memwrite. Next state FETCH.
  - RTYPEEX: alusrca, aluop=10. Next state RTYPEWB.
  - RTYPEWB: regwrite, regdst=1. Next state FETCH.
  - BEQEX: alusrca, alusrcb=00, pcsrc=01, aluop=01, branch. Next state FETCH.
  - ADDIEX: alusrca, alusrcb=10. Next state ADDIWB.
  - ADDIWB: regwrite, regdst=0, memtoreg=0. Next state FETCH.
  - JEX: pcsrc=10, pcwrite. Next state FETCH.
- Unreachable state encodings return to FETCH with all controls 0.

## Timing
- Reset clears the state to FETCH and clears PC, IR, Data, A, B and ALUOut to 0. The register file is not reset.
- During and immediately after reset: adr=0, memwrite=0, writedata=0.
- Reset asserted mid-instruction aborts the instruction; no partial register or memory write occurs after reset rises.
- The first fetch occurs in the first cycle after reset deasserts.
- Cycles per instruction:
  - lw: 5.
  - sw, R-type, addi: 4.
  - beq, j: 3.
  - Undefined opcode: 2.
- PC+4 is written at the end of FETCH.
- The branch target (PC+4+(imm<<2)) is computed in DECODE and held in ALUOut. BEQEX loads it into PC only when the zero flag is set.
- Register writes take effect at the clock edge ending the writeback state and are visible to the next instruction's DECODE.
- memwrite is high for exactly one cycle per sw, with adr=rs+signimm and writedata=rt.

## Test plan
- Reset: hold reset for 2 cycles -> adr=0, memwrite=0, and the state enters FETCH.
- addi $2,$0,5 at 0x0, then sw $2,84($0) at 0x4 -> in cycle 7 after reset release: memwrite=1, adr=84, writedata=5. No other cycle asserts memwrite.
- R-type chain:
  - Stimulus: addi $3,$0,12; addi $7,$0,3; sub $4,$3,$7; or $5,$3,$7; and $6,$3,$7; slt $8,$7,$3; sw of each result.
  - Required stores: 9, 15, 0, 1.
- lw/sw round trip: sw $2,80($0) then lw $9,80($0) then sw $9,84($0) -> stores to 80 and to 84 carry the same value.
- beq:
  - Taken (equal regs): skips the next instruction, PC = PC+4+4*imm.
  - Not taken: falls through; PC unchanged by BEQEX.
  - Negative offset branches backward.
- j 0x12: next fetch adr = 0x48. An undefined opcode advances PC by 4 and writes neither registers nor memory.
